// File: rtl/note_sequencer_pkg.sv
// Shared types and constants for the note sequencer: FSM states, note-entry bit positions, default sizes.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package audio_seq_pkg;

    localparam int STEPS_DEF   = 16;
    localparam int FREQ_W_DEF  = 12;
    localparam int TEMPO_W_DEF = 16;
    localparam int ENTRY_W     = 16;

    localparam int END_BIT  = 15;
    localparam int REST_BIT = 14;
    localparam int MASK_HI  = 13;
    localparam int MASK_LO  = 12;
    localparam int FREQ_HI  = 11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        APPLY = 2'd2,
        WAIT  = 2'd3
    } seq_state_t;

endpackage

// File: rtl/note_sequencer_if.sv
// Host/generator-facing bundle of the note sequencer: table programming, playback control, freq outputs.
// Latency: n/a (wiring only).
// Backpressure: none; all strobes are single-cycle and always accepted.
interface note_sequencer_if #(
    parameter int STEPS   = 16,
    parameter int FREQ_W  = 12,
    parameter int TEMPO_W = 16
);
    localparam int IDX_W = $clog2(STEPS);

    logic               frame_tick;
    logic               prog_we;
    logic [IDX_W-1:0]   prog_addr;
    logic [15:0]        prog_data;
    logic [TEMPO_W-1:0] tempo;
    logic               loop_en;
    logic               start;
    logic               stop;
    logic [1:0]         octave;
    logic [FREQ_W-1:0]  freq_ch1;
    logic [FREQ_W-1:0]  freq_ch2;
    logic [IDX_W-1:0]   step_idx;
    logic               busy;
    logic               step_pulse;
    logic               done;

    modport master (
        output frame_tick, prog_we, prog_addr, prog_data, tempo, loop_en, start, stop, octave,
        input  freq_ch1, freq_ch2, step_idx, busy, step_pulse, done
    );

    modport slave (
        input  frame_tick, prog_we, prog_addr, prog_data, tempo, loop_en, start, stop, octave,
        output freq_ch1, freq_ch2, step_idx, busy, step_pulse, done
    );

endinterface

// File: rtl/note_sequencer_table.sv
// Note table: STEPS x 16-bit storage, synchronous write, registered read, cleared by reset.
// Latency: rd_data valid one edge after rd_en; a same-edge write to the read address returns the old word.
// Backpressure: none; writes accepted every cycle, including during playback.
module seq_table #(
    parameter int STEPS = 16,
    parameter int W     = 16,
    parameter int IDX_W = $clog2(STEPS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [IDX_W-1:0] waddr,
    input  logic [W-1:0]     wdata,
    input  logic             rd_en,
    input  logic [IDX_W-1:0] raddr,
    output logic [W-1:0]     rd_data
);

    logic [W-1:0] mem [STEPS];

    // Read and write share one edge; nonblocking update gives read-before-write.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < STEPS; i++) begin
                mem[i] <= '0;
            end
            rd_data <= '0;
        end else begin
            if (rd_en) begin
                rd_data <= mem[raddr];
            end
            if (we) begin
                mem[waddr] <= wdata;
            end
        end
    end

endmodule

// File: rtl/note_sequencer.sv
// Note sequencer: steps through the note table on frame ticks and drives ch1/ch2 freq increments; SEQ_TRANSPOSE_EN adds octave shift.
// Latency: start -> freq/step_pulse after 3 edges; each step lasts tempo frame ticks plus 2 clocks of fetch.
// Backpressure: none; frame_tick and host strobes are sampled every cycle, nothing stalls.
module note_sequencer
    import audio_seq_pkg::*;
#(
    parameter int STEPS   = STEPS_DEF,
    parameter int FREQ_W  = FREQ_W_DEF,
    parameter int TEMPO_W = TEMPO_W_DEF
) (
    input  logic           clk,
    input  logic           rst,
    note_sequencer_if.slave bus
);

    localparam int IDX_W = $clog2(STEPS);

    seq_state_t         state, state_nxt;
    logic [IDX_W-1:0]   idx_q, idx_nxt;
    logic [TEMPO_W-1:0] cnt_q, cnt_nxt;
    logic [FREQ_W-1:0]  f1_q, f1_nxt;
    logic [FREQ_W-1:0]  f2_q, f2_nxt;
    logic               pulse_q, pulse_nxt;
    logic               done_q, done_nxt;
    logic [ENTRY_W-1:0] entry;
    logic [FREQ_W-1:0]  note_freq;

    seq_table #(
        .STEPS (STEPS),
        .W     (ENTRY_W)
    ) u_table (
        .clk     (clk),
        .rst     (rst),
        .we      (bus.prog_we),
        .waddr   (bus.prog_addr),
        .wdata   (bus.prog_data),
        .rd_en   (state == FETCH),
        .raddr   (idx_q),
        .rd_data (entry)
    );

`ifdef SEQ_TRANSPOSE_EN
    // Shift into 3 guard bits; anything landing there saturates the increment.
    logic [FREQ_W+2:0] shifted;
    assign shifted   = {3'b000, entry[FREQ_W-1:0]} << bus.octave;
    assign note_freq = (|shifted[FREQ_W+2:FREQ_W]) ? {FREQ_W{1'b1}} : shifted[FREQ_W-1:0];
`else
    logic unused_octave;
    assign unused_octave = ^bus.octave;
    assign note_freq     = entry[FREQ_W-1:0];
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            f1_q    <= '0;
            f2_q    <= '0;
            pulse_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state   <= state_nxt;
            idx_q   <= idx_nxt;
            cnt_q   <= cnt_nxt;
            f1_q    <= f1_nxt;
            f2_q    <= f2_nxt;
            pulse_q <= pulse_nxt;
            done_q  <= done_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx_q;
        cnt_nxt   = cnt_q;
        f1_nxt    = f1_q;
        f2_nxt    = f2_q;
        pulse_nxt = 1'b0;
        done_nxt  = 1'b0;

        if (state != IDLE && bus.stop) begin
            // Abort silences both channels and does not report completion.
            state_nxt = IDLE;
            idx_nxt   = '0;
            f1_nxt    = '0;
            f2_nxt    = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start && !bus.stop) begin
                        state_nxt = FETCH;
                    end
                end
                FETCH: begin
                    state_nxt = APPLY;
                end
                APPLY: begin
                    if (entry[END_BIT]) begin
                        // Looping from step 0 onto END would spin forever, so it terminates instead.
                        idx_nxt = '0;
                        if (bus.loop_en && idx_q != '0) begin
                            state_nxt = FETCH;
                        end else begin
                            state_nxt = IDLE;
                            done_nxt  = 1'b1;
                        end
                    end else begin
                        if (entry[MASK_LO]) begin
                            f1_nxt = entry[REST_BIT] ? '0 : note_freq;
                        end
                        if (entry[MASK_HI]) begin
                            f2_nxt = entry[REST_BIT] ? '0 : note_freq;
                        end
                        pulse_nxt = 1'b1;
                        cnt_nxt   = (bus.tempo == '0) ? TEMPO_W'(1) : bus.tempo;
                        state_nxt = WAIT;
                    end
                end
                WAIT: begin
                    if (bus.frame_tick) begin
                        if (cnt_q == TEMPO_W'(1)) begin
                            idx_nxt   = idx_q + IDX_W'(1);
                            state_nxt = FETCH;
                        end else begin
                            cnt_nxt = cnt_q - TEMPO_W'(1);
                        end
                    end
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    assign bus.freq_ch1   = f1_q;
    assign bus.freq_ch2   = f2_q;
    assign bus.step_idx   = idx_q;
    assign bus.busy       = (state != IDLE);
    assign bus.step_pulse = pulse_q;
    assign bus.done       = done_q;

endmodule

// File: tb/tb_note_sequencer.sv
// Scoreboard bench for note_sequencer: stimulus queues expected step/done events, a negedge monitor checks them.
// Event stamps are cycle numbers, so step timing (tempo ticks + fetch overhead) is checked too.
module tb_note_sequencer;
    import audio_seq_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    note_sequencer_if sif ();

    note_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (sif)
    );

    typedef struct {
        bit          is_done;
        int          stamp;
        logic [3:0]  idx;
        logic [11:0] f1;
        logic [11:0] f2;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    int   cyc    = 0;
    int   checks = 0;
    int   fails  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Every step_pulse or done must match the oldest queued expectation, including its cycle.
    always @(negedge clk) begin
        if (sif.step_pulse || sif.done) begin
            checks++;
            if (sbq.size() == 0) begin
                fails++;
                $display("FAIL unexpected_event cyc=%0d got pulse=%b done=%b idx=%0d f1=%h f2=%h required none",
                         cyc, sif.step_pulse, sif.done, sif.step_idx, sif.freq_ch1, sif.freq_ch2);
            end else begin
                mon_e = sbq.pop_front();
                if (sif.done !== mon_e.is_done || sif.step_pulse !== !mon_e.is_done ||
                    cyc != mon_e.stamp || sif.step_idx !== mon_e.idx ||
                    sif.freq_ch1 !== mon_e.f1 || sif.freq_ch2 !== mon_e.f2) begin
                    fails++;
                    $display("FAIL event got done=%b pulse=%b cyc=%0d idx=%0d f1=%h f2=%h required done=%b cyc=%0d idx=%0d f1=%h f2=%h",
                             sif.done, sif.step_pulse, cyc, sif.step_idx, sif.freq_ch1, sif.freq_ch2,
                             mon_e.is_done, mon_e.stamp, mon_e.idx, mon_e.f1, mon_e.f2);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d required finish earlier", cyc);
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%h required=%h", name, got, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] ent(input bit e, input bit r, input logic [1:0] m, input logic [11:0] f);
        return {e, r, m, f};
    endfunction

    task automatic wr(input logic [3:0] a, input logic [15:0] d);
        sif.prog_we   = 1'b1;
        sif.prog_addr = a;
        sif.prog_data = d;
        nxt();
        sif.prog_we   = 1'b0;
    endtask

    task automatic do_start(output int t);
        sif.start = 1'b1;
        t = cyc;
        nxt();
        sif.start = 1'b0;
    endtask

    task automatic tick(output int t, input int gap);
        sif.frame_tick = 1'b1;
        t = cyc;
        nxt();
        sif.frame_tick = 1'b0;
        repeat (gap) nxt();
    endtask

    task automatic push(input bit d, input int st, input logic [3:0] i, input logic [11:0] a, input logic [11:0] b);
        exp_t e;
        e.is_done = d;
        e.stamp   = st;
        e.idx     = i;
        e.f1      = a;
        e.f2      = b;
        sbq.push_back(e);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        nxt();
        rst = 1'b0;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_busy"}, 32'(sif.busy), 32'd0);
        chk({tag, "_f1"}, 32'(sif.freq_ch1), 32'd0);
        chk({tag, "_f2"}, 32'(sif.freq_ch2), 32'd0);
        chk({tag, "_idx"}, 32'(sif.step_idx), 32'd0);
    endtask

    logic [11:0] tp1, tp2;

    initial begin
        int t;
        sif.frame_tick = 1'b0;
        sif.prog_we    = 1'b0;
        sif.prog_addr  = '0;
        sif.prog_data  = '0;
        sif.tempo      = '0;
        sif.loop_en    = 1'b0;
        sif.start      = 1'b0;
        sif.stop       = 1'b0;
        sif.octave     = 2'd0;
        nxt();
        nxt();
        rst = 1'b0;

        chk_quiet("reset");
        chk("reset_pulse", 32'(sif.step_pulse), 32'd0);
        chk("reset_done", 32'(sif.done), 32'd0);

        // Basic sequence, tempo 3, no loop.
        wr(4'd0, ent(0, 0, 2'b01, 12'h100));
        wr(4'd1, ent(0, 0, 2'b10, 12'h200));
        wr(4'd2, ent(1, 0, 2'b00, 12'h000));
        sif.tempo   = 16'd3;
        sif.loop_en = 1'b0;
        do_start(t);
        push(0, t + 3, 4'd0, 12'h100, 12'h000);
        nxt(); nxt();
        tick(t, 2); tick(t, 2); tick(t, 2);
        push(0, t + 3, 4'd1, 12'h100, 12'h200);
        tick(t, 2); tick(t, 2); tick(t, 2);
        push(1, t + 3, 4'd0, 12'h100, 12'h200);
        repeat (3) nxt();
        chk("basic_busy_after", 32'(sif.busy), 32'd0);
        chk("basic_hold_f1", 32'(sif.freq_ch1), 32'h100);
        chk("basic_hold_f2", 32'(sif.freq_ch2), 32'h200);

        // Reset mid-playback clears outputs and the table.
        sif.tempo = 16'd1;
        do_start(t);
        push(0, t + 3, 4'd0, 12'h100, 12'h200);
        nxt(); nxt();
        do_reset();
        chk_quiet("midrst");
        wr(4'd1, ent(0, 0, 2'b11, 12'h0AB));
        do_start(t);
        push(0, t + 3, 4'd0, 12'h000, 12'h000);
        nxt(); nxt();
        tick(t, 2);
        push(0, t + 3, 4'd1, 12'h0AB, 12'h0AB);
        sif.stop = 1'b1;
        nxt();
        sif.stop = 1'b0;
        chk_quiet("stop1");

        // Loop, then stop with a simultaneous start while in WAIT.
        do_reset();
        wr(4'd0, ent(0, 0, 2'b01, 12'h100));
        wr(4'd1, ent(0, 0, 2'b10, 12'h200));
        wr(4'd2, ent(1, 0, 2'b00, 12'h000));
        sif.tempo   = 16'd3;
        sif.loop_en = 1'b1;
        do_start(t);
        push(0, t + 3, 4'd0, 12'h100, 12'h000);
        nxt(); nxt();
        tick(t, 2); tick(t, 2); tick(t, 2);
        push(0, t + 3, 4'd1, 12'h100, 12'h200);
        tick(t, 2); tick(t, 2); tick(t, 2);
        push(0, t + 5, 4'd0, 12'h100, 12'h200);
        nxt(); nxt();
        sif.stop  = 1'b1;
        sif.start = 1'b1;
        nxt();
        sif.stop  = 1'b0;
        sif.start = 1'b0;
        chk_quiet("stop_start");
        repeat (4) nxt();
        chk("stop_stays_idle", 32'(sif.busy), 32'd0);

        // REST on both channels with tempo 0 (one tick per step).
        do_reset();
        wr(4'd0, ent(0, 0, 2'b11, 12'h321));
        wr(4'd1, ent(0, 1, 2'b11, 12'h777));
        wr(4'd2, ent(1, 0, 2'b00, 12'h000));
        sif.tempo   = 16'd0;
        sif.loop_en = 1'b0;
        do_start(t);
        push(0, t + 3, 4'd0, 12'h321, 12'h321);
        nxt(); nxt();
        tick(t, 2);
        push(0, t + 3, 4'd1, 12'h000, 12'h000);
        tick(t, 2);
        push(1, t + 3, 4'd0, 12'h000, 12'h000);
        nxt(); nxt();

        // END at step 0 with loop enabled terminates at once.
        wr(4'd0, ent(1, 0, 2'b11, 12'hFFF));
        sif.loop_en = 1'b1;
        do_start(t);
        push(1, t + 3, 4'd0, 12'h000, 12'h000);
        repeat (4) nxt();
        chk("end0_loop_idle", 32'(sif.busy), 32'd0);
        sif.loop_en = 1'b0;

        // Writes while busy: next-step update and read-before-write collision.
        do_reset();
        sif.tempo = 16'd1;
        wr(4'd0, ent(0, 0, 2'b01, 12'h111));
        wr(4'd1, ent(0, 0, 2'b01, 12'h222));
        wr(4'd2, ent(1, 0, 2'b00, 12'h000));
        do_start(t);
        push(0, t + 3, 4'd0, 12'h111, 12'h000);
        nxt(); nxt();
        wr(4'd1, ent(0, 0, 2'b10, 12'h333));
        nxt();
        tick(t, 2);
        push(0, t + 3, 4'd1, 12'h111, 12'h333);
        tick(t, 0);
        wr(4'd2, ent(0, 0, 2'b01, 12'h444));
        push(1, t + 3, 4'd0, 12'h111, 12'h333);
        repeat (3) nxt();
        do_start(t);
        push(0, t + 3, 4'd0, 12'h111, 12'h333);
        nxt(); nxt();
        tick(t, 2);
        push(0, t + 3, 4'd1, 12'h111, 12'h333);
        tick(t, 2);
        push(0, t + 3, 4'd2, 12'h444, 12'h333);
        nxt();
        sif.stop = 1'b1;
        nxt();
        sif.stop = 1'b0;
        chk_quiet("stop2");

        // Octave shift: saturates when enabled, ignored otherwise.
`ifdef SEQ_TRANSPOSE_EN
        tp1 = 12'hFFF;
        tp2 = 12'h400;
`else
        tp1 = 12'h500;
        tp2 = 12'h100;
`endif
        do_reset();
        sif.octave = 2'd2;
        wr(4'd0, ent(0, 0, 2'b01, 12'h500));
        wr(4'd1, ent(0, 0, 2'b10, 12'h100));
        wr(4'd2, ent(1, 0, 2'b00, 12'h000));
        do_start(t);
        push(0, t + 3, 4'd0, tp1, 12'h000);
        nxt(); nxt();
        tick(t, 2);
        push(0, t + 3, 4'd1, tp1, tp2);
        tick(t, 2);
        push(1, t + 3, 4'd0, tp1, tp2);
        repeat (3) nxt();

        chk("scoreboard_drained", 32'(sbq.size()), 32'd0);
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
